fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO: the next-generation replacement for the fixed 8-bit, 16-deep FIFO, generalised in data width and depth. It adds parameter-set almost-empty/almost-full thresholds, an occupancy count, sticky overflow/underflow error flags and a first-word-fall-through (FWFT) read mode. It sits between LFSR-driven or upstream producers and downstream consumers on the single system clock. Benches compare it against a behavioural model exactly as for the existing FIFO.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AE_LEVEL, 2, PEF asserted when COUNT ≤ AE_LEVEL (0 ≤ AE_LEVEL < DEPTH)
- AF_LEVEL, 14, PFF asserted when COUNT ≥ AF_LEVEL (0 < AF_LEVEL ≤ DEPTH)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- clk  in  1  clock, all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- DATA_IN  in  WIDTH  write data
- WE  in  1  write enable
- RE  in  1  read enable
- CLR_ERR  in  1  clears OVF/UDF (synchronous)
- DOUT  out  WIDTH  read data
- EF  out  1  empty (COUNT == 0)
- PEF  out  1  partially empty (COUNT ≤ AE_LEVEL)
- FF  out  1  full (COUNT == DEPTH)
- PFF  out  1  partially full (COUNT ≥ AF_LEVEL)
- COUNT  out  $clog2(DEPTH)+1  current occupancy
- OVF  out  1  sticky: write attempted while full and not accepted
- UDF  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×WIDTH array. Write and read pointers are $clog2(DEPTH)+1 bits, wrapping naturally modulo 2·DEPTH. Address = low bits.
- Write accepted when WE=1 and (FF=0, or RE=1 with FF=1). Word stored at wr_ptr; wr_ptr++.
- Read accepted when RE=1 and EF=0. rd_ptr++.
- Simultaneous WE=RE=1:
  - not empty, not full: both accepted, COUNT unchanged.
  - full: both accepted (read frees the slot), COUNT stays DEPTH, OVF not set.
  - empty: write accepted, read rejected, UDF set, COUNT becomes 1.
- WE=1 on full with RE=0: write dropped, memory and pointers unchanged, OVF←1.
- RE=1 on empty: no pointer change, DOUT unchanged (standard mode), UDF←1.
- COUNT = wr_ptr − rd_ptr, held in a register updated with the pointers. All flags decode from registered COUNT.
- OVF/UDF hold until RESET or CLR_ERR=1. If CLR_ERR and a new error occur in the same cycle, the flag stays 1.
- FWFT=0: DOUT is a register loaded with mem[rd_ptr] on an accepted read, otherwise held.
- FWFT=1: DOUT = mem[rd_ptr] whenever EF=0 and is 0 when EF=1. RE pops the presented word.

## Timing
- RESET=1 at a rising edge: pointers=0, COUNT=0, DOUT=0, EF=1, PEF=1, FF=0, PFF=0, OVF=0, UDF=0. Memory contents are not cleared.
- RESET dominates WE/RE/CLR_ERR in the same cycle. A mid-operation reset discards all stored data.
- All outputs change only after a rising edge; none depend combinationally on WE/RE/DATA_IN.
- Write at edge k: COUNT/EF/PEF/FF/PFF reflect it after edge k (1-cycle latency).
- FWFT=0 read at edge k: DOUT valid after edge k.
- FWFT=1: a word written at edge k into an empty FIFO appears on DOUT after edge k.
- Back-to-back reads and writes are sustained at one per cycle. Wrap-around is seamless.

## Test plan
- Reset: drive RESET=1 for 2 cycles mid-traffic with COUNT=9 -> after the edge, COUNT=0, EF=1, PEF=1, FF=0, PFF=0, DOUT=0, OVF=UDF=0; a subsequent read sets UDF=1.
- Fill/drain (WIDTH=8, DEPTH=16, AE=2, AF=14, FWFT=0): write 1..16 -> PEF clears at COUNT=3, PFF sets at 14, FF at 16. A 17th write sets OVF=1 and leaves COUNT=16. Read 16 -> DOUT 1..16 in order, EF=1 after the last read.
- Simultaneous access: full FIFO + WE=RE=1 with DATA_IN=0xAA -> COUNT stays 16, OVF=0, 0xAA read last. Empty FIFO + WE=RE=1 -> COUNT=1, UDF=1.
- Wrap-around: 40 cycles of continuous WE=RE=1 at COUNT=5 with LFSR data -> DOUT sequence matches the behavioural model, COUNT constant at 5.
- FWFT=1: write 0x3C into an empty FIFO -> DOUT=0x3C and EF=0 one edge later, no RE needed. RE then -> EF=1, DOUT=0.
- CLR_ERR: set OVF, pulse CLR_ERR -> OVF=0 next edge. CLR_ERR coincident with a new overflow -> OVF stays 1.

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with programmable almost-empty/almost-full
// thresholds, occupancy count, sticky error flags and optional FWFT read mode.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AE_LEVEL = 2,
    parameter int AF_LEVEL = 14,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic [WIDTH-1:0]         DATA_IN,
    input  logic                     WE,
    input  logic                     RE,
    input  logic                     CLR_ERR,
    output logic [WIDTH-1:0]         DOUT,
    output logic                     EF,
    output logic                     PEF,
    output logic                     FF,
    output logic                     PFF,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVF,
    output logic                     UDF
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ef_q, ef_d;
    logic             pef_q, pef_d;
    logic             ff_q, ff_d;
    logic             pff_q, pff_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             new_ovf_s;
    logic             new_udf_s;
    logic [WIDTH-1:0] head_s;

    // Accept/reject decisions, taken from the registered full/empty flags.
    always_comb begin
        wr_acc_s  = WE & (~ff_q | RE);
        rd_acc_s  = RE & ~ef_q;
        new_ovf_s = WE & ff_q & ~RE;
        new_udf_s = RE & ef_q;
    end

    // Pointer advance and occupancy, with the flags decoded from next COUNT.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = wr_ptr_d - rd_ptr_d;
        ef_d    = (count_d == {PW{1'b0}});
        pef_d   = (count_d <= AE_C);
        ff_d    = (count_d == DEPTH_C);
        pff_d   = (count_d >= AF_C);
    end

    // Sticky error flags: a new error in the same cycle beats CLR_ERR.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (new_ovf_s) begin
            ovf_d = 1'b1;
        end else if (CLR_ERR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (new_udf_s) begin
            udf_d = 1'b1;
        end else if (CLR_ERR) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Read data: FWFT presents the next head word (bypassing a word written
    // into an empty slot this cycle); standard mode loads on an accepted read.
    always_comb begin
        head_s = mem_q[rd_ptr_d[AW-1:0]];
        if (wr_acc_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            head_s = DATA_IN;
        end else begin
            head_s = mem_q[rd_ptr_d[AW-1:0]];
        end
        dout_d = dout_q;
        if (FWFT != 0) begin
            if (count_d == {PW{1'b0}}) begin
                dout_d = {WIDTH{1'b0}};
            end else begin
                dout_d = head_s;
            end
        end else begin
            if (rd_acc_s) begin
                dout_d = mem_q[rd_ptr_q[AW-1:0]];
            end else begin
                dout_d = dout_q;
            end
        end
    end

    // Storage array, never reset; stale contents are unreachable after reset.
    always_ff @(posedge clk) begin
        if (!RESET && wr_acc_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= DATA_IN;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RESET) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {PW{1'b0}};
            dout_q   <= {WIDTH{1'b0}};
            ef_q     <= 1'b1;
            pef_q    <= 1'b1;
            ff_q     <= 1'b0;
            pff_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ef_q     <= ef_d;
            pef_q    <= pef_d;
            ff_q     <= ff_d;
            pff_q    <= pff_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign DOUT  = dout_q;
    assign EF    = ef_q;
    assign PEF   = pef_q;
    assign FF    = ff_q;
    assign PFF   = pff_q;
    assign COUNT = count_q;
    assign OVF   = ovf_q;
    assign UDF   = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench: a standard-read and an FWFT instance share
// the same stimulus; expected values are hand-derived or from a queue model.
module tb_fifo_param;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       we, re, clr_err;

    logic [7:0] dout_s, dout_f;
    logic       ef_s, pef_s, ff_s, pff_s, ovf_s, udf_s;
    logic       ef_f, pef_f, ff_f, pff_f, ovf_f, udf_f;
    logic [4:0] count_s, count_f;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q [$];
    logic [7:0] lfsr;
    logic [7:0] exp_w;

    fifo_param #(.WIDTH(8), .DEPTH(16), .AE_LEVEL(2), .AF_LEVEL(14), .FWFT(0)) u_std (
        .clk(clk), .RESET(reset), .DATA_IN(data_in), .WE(we), .RE(re), .CLR_ERR(clr_err),
        .DOUT(dout_s), .EF(ef_s), .PEF(pef_s), .FF(ff_s), .PFF(pff_s),
        .COUNT(count_s), .OVF(ovf_s), .UDF(udf_s)
    );

    fifo_param #(.WIDTH(8), .DEPTH(16), .AE_LEVEL(2), .AF_LEVEL(14), .FWFT(1)) u_fwft (
        .clk(clk), .RESET(reset), .DATA_IN(data_in), .WE(we), .RE(re), .CLR_ERR(clr_err),
        .DOUT(dout_f), .EF(ef_f), .PEF(pef_f), .FF(ff_f), .PFF(pff_f),
        .COUNT(count_f), .OVF(ovf_f), .UDF(udf_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d);
        we      = w;
        re      = r;
        clr_err = c;
        data_in = d;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_count"}, count_s, 0);
        check_eq({tag, "_ef"},    ef_s,    1);
        check_eq({tag, "_pef"},   pef_s,   1);
        check_eq({tag, "_ff"},    ff_s,    0);
        check_eq({tag, "_pff"},   pff_s,   0);
        check_eq({tag, "_dout"},  dout_s,  0);
        check_eq({tag, "_ovf"},   ovf_s,   0);
        check_eq({tag, "_udf"},   udf_s,   0);
        check_eq({tag, "_doutf"}, dout_f,  0);
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("init");

        // Fill 1..16 with flag thresholds
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(k));
            tick();
            check_eq($sformatf("fill%0d_count", k), count_s, k);
            check_eq($sformatf("fill%0d_pef", k), pef_s, (k <= 2) ? 1 : 0);
            check_eq($sformatf("fill%0d_pff", k), pff_s, (k >= 14) ? 1 : 0);
            check_eq($sformatf("fill%0d_ff", k), ff_s, (k == 16) ? 1 : 0);
        end
        check_eq("fwft_head_full", dout_f, 8'h01);

        drive(1'b1, 1'b0, 1'b0, 8'h77);
        tick();
        check_eq("ovf_set", ovf_s, 1);
        check_eq("ovf_count", count_s, 16);

        drive(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check_eq("clr_ovf", ovf_s, 0);
        drive(1'b1, 1'b0, 1'b1, 8'h78);
        tick();
        check_eq("clr_vs_new_ovf", ovf_s, 1);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check_eq("clr_ovf2", ovf_s, 0);

        // Drain 16
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            check_eq($sformatf("drain%0d_dout", k), dout_s, k);
            check_eq($sformatf("drain%0d_count", k), count_s, 16 - k);
            check_eq($sformatf("drain%0d_doutf", k), dout_f, (k < 16) ? k + 1 : 0);
        end
        check_eq("drain_ef", ef_s, 1);
        check_eq("drain_udf", udf_s, 0);

        // Simultaneous access on empty
        drive(1'b1, 1'b1, 1'b0, 8'h55);
        tick();
        check_eq("empty_rw_count", count_s, 1);
        check_eq("empty_rw_udf", udf_s, 1);
        check_eq("empty_rw_dout_held", dout_s, 8'h10);
        check_eq("empty_rw_doutf", dout_f, 8'h55);
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        check_eq("clr_udf", udf_s, 0);
        check_eq("read55", dout_s, 8'h55);
        check_eq("read55_count", count_s, 0);

        // Simultaneous access on full
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h20 + k));
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 8'hAA);
        tick();
        check_eq("full_rw_count", count_s, 16);
        check_eq("full_rw_ovf", ovf_s, 0);
        check_eq("full_rw_dout", dout_s, 8'h20);
        check_eq("full_rw_doutf", dout_f, 8'h21);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            check_eq($sformatf("full_drain%0d", k), dout_s, (k < 16) ? 8'h20 + k : 8'hAA);
        end
        check_eq("full_drain_ef", ef_s, 1);

        // FWFT presentation without RE, then pop
        drive(1'b1, 1'b0, 1'b0, 8'h3C);
        tick();
        check_eq("fwft_dout", dout_f, 8'h3C);
        check_eq("fwft_ef", ef_f, 0);
        check_eq("std_dout_held", dout_s, 8'hAA);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        check_eq("fwft_pop_ef", ef_f, 1);
        check_eq("fwft_pop_dout", dout_f, 8'h00);
        check_eq("std_pop_dout", dout_s, 8'h3C);

        // Wrap-around with LFSR data at COUNT=5
        lfsr = 8'hB5;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, lfsr);
            model_q.push_back(lfsr);
            lfsr = lfsr_next(lfsr);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 1'b1, 1'b0, lfsr);
            exp_w = model_q.pop_front();
            model_q.push_back(lfsr);
            lfsr = lfsr_next(lfsr);
            tick();
            check_eq($sformatf("wrap%0d_dout", k), dout_s, exp_w);
            check_eq($sformatf("wrap%0d_count", k), count_s, 5);
            check_eq($sformatf("wrap%0d_doutf", k), dout_f, model_q[0]);
        end

        // Mid-traffic reset at COUNT=9, with WE held to show reset dominance
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h90 + k));
            tick();
        end
        check_eq("pre_reset_count", count_s, 9);
        drive(1'b1, 1'b1, 1'b1, 8'hEE);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_reset_state("midrst");
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        check_eq("post_rst_udf", udf_s, 1);
        check_eq("post_rst_count", count_s, 0);
        check_eq("post_rst_dout", dout_s, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
